xmr_tap_capture: RTL
====================

Name: xmr_tap_capture

Overview:
- Parametrised, multi-channel capture block that sits in the top level.
- It collects the `__xmr__` export ports that XMR elimination produces from NUM_CH sub-module internal signals.
- It arms on request and waits for a per-mode trigger on one selected channel.
- It then records DEPTH consecutive samples and drains them over a valid/ready read port.
- It replaces ad-hoc `assign result = <flattened xmr>` usage with a buffered, triggered debug tap.

Parameters:
NUM_CH, 4, number of probe channels (>=1)
DATA_W, 8, width of each probe channel
DEPTH, 16, capture buffer entries (power of two, >=2)
CH_W, $clog2(NUM_CH) (min 1), derived channel-select width
PTR_W, $clog2(DEPTH), derived buffer pointer width

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
probe_i  input  NUM_CH*DATA_W  flattened probe channels; channel k = probe_i[k*DATA_W +: DATA_W]
cfg_ch_i  input  CH_W  channel select, latched on arm
cfg_mode_i  input  2  trigger mode, latched on arm: 0=change, 1=match, 2=immediate, 3=treated as immediate
cfg_match_i  input  DATA_W  match value for mode 1, latched on arm
arm_i  input  1  start request, honoured only in IDLE
abort_i  input  1  return to IDLE from any state
state_o  output  2  current state: IDLE=0, ARMED=1, CAPTURE=2, DRAIN=3
rd_valid_o  output  1  read data valid
rd_ready_i  input  1  read consumer ready
rd_data_o  output  DATA_W  captured sample
rd_last_o  output  1  marks entry DEPTH-1

Behaviour:
- Reset (async assert, sync release): state IDLE; rd_valid_o=0, rd_data_o=0, rd_last_o=0; pointers and latched config cleared; prev-sample register cleared.
- sel = selected channel of probe_i, using the latched cfg_ch. cfg_ch >= NUM_CH selects channel 0.
- prev register holds sel from the previous cycle and updates every cycle in every state.
- IDLE: when arm_i=1, latch cfg_ch/cfg_mode/cfg_match and go to ARMED next cycle.
- ARMED: the trigger is evaluated each cycle.
  - mode 0: sel != prev. The first ARMED cycle compares against a prev captured with the new channel select.
  - mode 1: sel == cfg_match.
  - mode 2/3: true on the first ARMED cycle.
- On the trigger cycle, sel is written to entry 0 and the state goes to CAPTURE with wr_ptr=1.
- CAPTURE: write sel to entry wr_ptr every cycle. Samples are consecutive; no gaps are allowed.
  - After writing entry DEPTH-1, go to DRAIN. Total DEPTH samples: trigger cycle plus DEPTH-1 cycles.
- DRAIN: rd_valid_o rises the first cycle in DRAIN with entry 0 (registered read, 1-cycle latency from entering DRAIN).
  - A transfer occurs when rd_valid_o && rd_ready_i. The next entry is presented the following cycle, allowing back-to-back transfers.
  - While rd_valid_o && !rd_ready_i, rd_data_o and rd_last_o hold stable.
  - rd_last_o=1 only with entry DEPTH-1. After that transfer: rd_valid_o=0, rd_last_o=0, state IDLE next cycle.
- abort_i=1 in any state: next cycle state IDLE, rd_valid_o=0, rd_last_o=0, pointers cleared.
  - abort_i takes priority over arm_i, trigger and transfer in the same cycle.
  - Buffer contents are don't-care after abort.
- arm_i outside IDLE is ignored. The config inputs are sampled only at arm.
- Pointer wrap: PTR_W wide, wraps naturally. End conditions use explicit compare to DEPTH-1, never to overflow.
- Reset mid-operation: immediate return to reset values. No partial drain is resumed.

Decomposition:
- Package xmr_tap_pkg:
  - state_e enum (IDLE, ARMED, CAPTURE, DRAIN, 2 bits).
  - mode_e enum (MODE_CHANGE, MODE_MATCH, MODE_IMM, MODE_RSVD).
  - Helper function extracting channel k from the flattened bus.
- One sub-module, xmr_tap_buf: DEPTH x DATA_W storage with write port (we, waddr, wdata) and registered read port (re, raddr, rdata). No reset on storage.
- FSM, trigger logic and handshake live in xmr_tap_capture.

Test Plan:
- Reset: assert rst_n=0 mid-clock -> state_o=0, rd_valid_o=0, rd_data_o=0 immediately, with no clock edge needed.
- Immediate mode: ch2 = cycle counter starting 0x10 at the arm cycle, mode 2, rd_ready_i=1 -> 16 outputs 0x11..0x20 consecutively; rd_last_o only on 0x20; state returns to 0.
- Match mode: ch1 ramps 0x00,0x01,...; cfg_match=0x05 -> first output 0x05, last 0x14; nothing captured before match.
- Change mode: ch0 = toggle register (0/1 each cycle, held at 0 for 5 cycles after arm, then toggling) -> capture begins on first 0->1; outputs alternate 1,0,1,...
- Backpressure: rd_ready_i pattern 1,0,0,1 repeating -> every entry delivered exactly once in order; rd_data_o stable during ready=0 cycles.
- Abort/ignored arm: arm_i pulsed during CAPTURE has no effect; abort_i at CAPTURE entry 7 -> state_o=0 next cycle, rd_valid_o never asserts; a following arm captures fresh data.

Source files
------------

// File: rtl/xmr_tap_pkg.sv
// Shared types and the channel extraction helper for the XMR tap capture block.
package xmr_tap_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DRAIN   = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      MODE_CHANGE = 2'd0,
      MODE_MATCH  = 2'd1,
      MODE_IMM    = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_e;

   // Upper bounds for the helper below; callers widen their bus to these.
   localparam int unsigned XMR_MAX_BUS_W  = 1024;
   localparam int unsigned XMR_MAX_DATA_W = 64;

   // Return channel k (w bits wide) of a flattened probe bus, zero-extended.
   function automatic logic [XMR_MAX_DATA_W-1:0] xmr_chan(
      input logic [XMR_MAX_BUS_W-1:0] bus,
      input int unsigned              k,
      input int unsigned              w
   );
      logic [XMR_MAX_BUS_W-1:0]  shifted;
      logic [XMR_MAX_DATA_W-1:0] res;
      shifted = bus >> (k * w);
      res     = '0;
      for (int unsigned i = 0; i < XMR_MAX_DATA_W; i++) begin
         if (i < w) res[i] = shifted[i];
      end
      return res;
   endfunction

endpackage

// File: rtl/xmr_tap_capture_if.sv
// Valid/ready read port carrying captured samples out of the tap.
interface xmr_tap_capture_if #(
   parameter int DATA_W = 8
);
   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;
   logic              rd_last;

   modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
   modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/xmr_tap_buf.sv
// Capture storage: one write port, one registered read port, no reset on the array.
module xmr_tap_buf #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [PTR_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [PTR_W-1:0]  raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port.
   always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   // Registered read; rdata_o holds while re_i is low.
   always_ff @(posedge clk) begin
      if (re_i) rdata_o <= mem[raddr_i];
   end

endmodule

// File: rtl/xmr_tap_capture.sv
// Triggered multi-channel capture of flattened XMR export probes with a buffered drain port.
module xmr_tap_capture
   import xmr_tap_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH*DATA_W-1:0] probe_i,
   input  logic [CH_W-1:0]          cfg_ch_i,
   input  logic [1:0]               cfg_mode_i,
   input  logic [DATA_W-1:0]        cfg_match_i,
   input  logic                     arm_i,
   input  logic                     abort_i,
   output logic [1:0]               state_o,
   xmr_tap_capture_if.master        rd_if
);

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   mode_e             mode_q, mode_d;
   logic [DATA_W-1:0] match_q, match_d;
   logic [DATA_W-1:0] prev_q, prev_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_last_q, rd_last_d;

   logic [XMR_MAX_BUS_W-1:0] probe_ext;
   logic [DATA_W-1:0]        sel;
   logic [DATA_W-1:0]        arm_sel;
   logic                     trig;
   logic                     we;
   logic [PTR_W-1:0]         waddr;
   logic                     re;
   logic [PTR_W-1:0]         raddr;
   logic [DATA_W-1:0]        buf_rdata;

   assign probe_ext = XMR_MAX_BUS_W'(probe_i);
   // Out-of-range selects fall back to channel 0.
   assign sel     = DATA_W'(xmr_chan(probe_ext, (32'(ch_q) < NUM_CH) ? 32'(ch_q) : 32'd0, DATA_W));
   // Channel seen through the select being armed, so change mode starts from a coherent prev.
   assign arm_sel = DATA_W'(xmr_chan(probe_ext, (32'(cfg_ch_i) < NUM_CH) ? 32'(cfg_ch_i) : 32'd0, DATA_W));

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ch_q       <= '0;
         mode_q     <= MODE_CHANGE;
         match_q    <= '0;
         prev_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         mode_q     <= mode_d;
         match_q    <= match_d;
         prev_q     <= prev_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
      end
   end

   // Next-state, trigger, buffer control and read handshake.
   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      mode_d     = mode_q;
      match_d    = match_q;
      prev_d     = sel;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      rd_valid_d = rd_valid_q;
      rd_last_d  = rd_last_q;
      trig       = 1'b0;
      we         = 1'b0;
      waddr      = wr_ptr_q;
      re         = 1'b0;
      raddr      = rd_ptr_q;

      case (state_q)
         IDLE: begin
            if (arm_i) begin
               state_d  = ARMED;
               ch_d     = cfg_ch_i;
               mode_d   = mode_e'(cfg_mode_i);
               match_d  = cfg_match_i;
               prev_d   = arm_sel;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
            end
         end
         ARMED: begin
            case (mode_q)
               MODE_CHANGE: trig = (sel != prev_q);
               MODE_MATCH:  trig = (sel == match_q);
               default:     trig = 1'b1;
            endcase
            if (trig) begin
               we       = 1'b1;
               waddr    = '0;
               wr_ptr_d = PTR_W'(1);
               state_d  = CAPTURE;
            end
         end
         CAPTURE: begin
            we       = 1'b1;
            waddr    = wr_ptr_q;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (wr_ptr_q == PTR_LAST) begin
               // Prefetch entry 0 so it is valid on the first DRAIN cycle.
               state_d    = DRAIN;
               re         = 1'b1;
               raddr      = '0;
               rd_ptr_d   = PTR_W'(1);
               rd_valid_d = 1'b1;
               rd_last_d  = 1'b0;
            end
         end
         DRAIN: begin
            if (rd_valid_q && rd_if.rd_ready) begin
               if (rd_last_q) begin
                  rd_valid_d = 1'b0;
                  rd_last_d  = 1'b0;
                  rd_ptr_d   = '0;
                  state_d    = IDLE;
               end else begin
                  re        = 1'b1;
                  raddr     = rd_ptr_q;
                  rd_last_d = (rd_ptr_q == PTR_LAST);
                  rd_ptr_d  = rd_ptr_q + PTR_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort overrides everything above, including a same-cycle arm.
      if (abort_i) begin
         state_d    = IDLE;
         ch_d       = ch_q;
         mode_d     = mode_q;
         match_d    = match_q;
         prev_d     = sel;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         rd_valid_d = 1'b0;
         rd_last_d  = 1'b0;
         we         = 1'b0;
         re         = 1'b0;
      end
   end

   xmr_tap_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_buf (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (sel),
      .re_i    (re),
      .raddr_i (raddr),
      .rdata_o (buf_rdata)
   );

   assign state_o        = state_q;
   assign rd_if.rd_valid = rd_valid_q;
   assign rd_if.rd_last  = rd_last_q;
   // Data is forced to zero whenever nothing is presented, including straight out of reset.
   assign rd_if.rd_data  = rd_valid_q ? buf_rdata : '0;

endmodule
